// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^4)/GF((2^4)^2) helpers for the SubBytes, MixColumns and key-schedule blocks.
// The isomorphism matrices are derived at elaboration time from the field polynomials.
package aes_pkg;
    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_fsm_e;

    localparam byte_t      SBOX_AFFINE_C = 8'h63;
    localparam byte_t      INV_AFFINE_C  = 8'h05;
    localparam logic [4:0] GF4_POLY      = 5'h13;  // x^4 + x + 1

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'(GF4_POLY) << (i - 4));
        return p[3:0];
    endfunction

    // Smallest lambda with y^2 + y + lambda irreducible over GF(2^4).
    function automatic logic [3:0] find_lambda();
        logic [3:0] lam;
        logic       hit;
        lam = '0;
        for (int l = 15; l >= 1; l--) begin
            hit = 1'b0;
            for (int t = 0; t < 16; t++)
                if ((gf4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) hit = 1'b1;
            if (!hit) lam = 4'(l);
        end
        return lam;
    endfunction

    localparam logic [3:0] CF_LAMBDA = find_lambda();

    function automatic logic [3:0] gf4_sq_scale(input logic [3:0] a);
        return gf4_mul(gf4_mul(a, a), CF_LAMBDA);
    endfunction

    // Composite element {h, l} = h*y + l with y^2 = y + lambda.
    function automatic byte_t cf_mul(input byte_t a, input byte_t b);
        logic [3:0] hh;
        hh = gf4_mul(a[7:4], b[7:4]);
        return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
                gf4_mul(hh, CF_LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
    endfunction

    function automatic byte_t lin_map(input logic [63:0] cols, input byte_t x);
        byte_t r;
        r = '0;
        for (int i = 0; i < 8; i++) if (x[i]) r = r ^ cols[8*i +: 8];
        return r;
    endfunction

    // Columns are beta^i where beta is a root of the AES polynomial inside the composite field.
    function automatic logic [63:0] build_iso();
        logic [63:0] cols;
        byte_t       beta, c, c2, c4, pw;
        logic        found;
        found = 1'b0;
        beta  = 8'h01;
        for (int k = 1; k < 256; k++) begin
            c  = byte_t'(k);
            c2 = cf_mul(c, c);
            c4 = cf_mul(c2, c2);
            if (!found && ((cf_mul(c4, c4) ^ c4 ^ cf_mul(c2, c) ^ c ^ 8'h01) == 8'h00)) begin
                beta  = c;
                found = 1'b1;
            end
        end
        pw = 8'h01;
        for (int i = 0; i < 8; i++) begin
            cols[8*i +: 8] = pw;
            pw = cf_mul(pw, beta);
        end
        return cols;
    endfunction

    localparam logic [63:0] ISO_COLS = build_iso();

    function automatic logic [63:0] build_inv_iso();
        logic [63:0] cols;
        cols = '0;
        for (int j = 0; j < 8; j++)
            for (int x = 0; x < 256; x++)
                if (lin_map(ISO_COLS, byte_t'(x)) == byte_t'(1 << j)) cols[8*j +: 8] = byte_t'(x);
        return cols;
    endfunction

    localparam logic [63:0] INV_ISO_COLS = build_inv_iso();

    function automatic byte_t rotl8(input byte_t v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic byte_t fwd_affine(input byte_t z);
        return z ^ rotl8(z, 1) ^ rotl8(z, 2) ^ rotl8(z, 3) ^ rotl8(z, 4) ^ SBOX_AFFINE_C;
    endfunction

    function automatic byte_t inv_affine(input byte_t x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ INV_AFFINE_C;
    endfunction
endpackage

// File: rtl/aes_gf4_inv.sv
// GF(2^4) multiplicative inverse (poly x^4+x+1) computed as a^14; zero maps to zero.
module aes_gf4_inv
    import aes_pkg::*;
(
    input  logic [3:0] a,
    output logic [3:0] y
);
    logic [3:0] a2, a4, a8;

    assign a2 = gf4_mul(a, a);
    assign a4 = gf4_mul(a2, a2);
    assign a8 = gf4_mul(a4, a4);
    assign y  = gf4_mul(gf4_mul(a8, a4), a2);
endmodule

// File: rtl/aes_sbox_cf.sv
// Composite-field AES S-box; inv selects InvSubBytes (inverse affine before the shared inversion path).
module aes_sbox_cf
    import aes_pkg::*;
(
    input  byte_t x,
    input  logic  inv,
    output byte_t y
);
    byte_t      pre, a, b, z;
    logic [3:0] delta, dinv;

    assign pre   = inv ? inv_affine(x) : x;
    assign a     = lin_map(ISO_COLS, pre);
    // Norm of a = h*y + l; inverse is (h*y + (h^l)) / norm.
    assign delta = gf4_sq_scale(a[7:4]) ^ gf4_mul(a[7:4], a[3:0]) ^ gf4_mul(a[3:0], a[3:0]);

    aes_gf4_inv u_gf4_inv (
        .a(delta),
        .y(dinv)
    );

    assign b = {gf4_mul(a[7:4], dinv), gf4_mul(a[7:4] ^ a[3:0], dinv)};
    assign z = lin_map(INV_ISO_COLS, b);
    assign y = inv ? z : fwd_affine(z);
endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes: NUM_SBOX bytes per cycle over NUM_ITER cycles, in-place in a working register.
// Handshakes: a transfer happens on a clk edge where valid and ready are both high; valid holds until then.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  state_t   in_state,
    input  logic     in_inv,
    output logic     out_valid,
    input  logic     out_ready,
    output state_t   out_state,
    output logic     busy,
    output sub_fsm_e fsm_state
);
    localparam int NUM_ITER = 16 / NUM_SBOX;
    localparam int CNT_W    = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITER - 1);

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
        $error("aes_sub_bytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    // work[0] is byte 0, the most significant byte of the state.
    logic [0:15][7:0] work;
    logic [CNT_W-1:0] cnt;
    logic             inv_q;
    logic [3:0]       base;
    byte_t            sub_in  [NUM_SBOX];
    byte_t            sub_out [NUM_SBOX];

    assign base      = 4'(32'(cnt) * NUM_SBOX);
    assign out_state = work;

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
        assign sub_in[k] = work[base + 4'(k)];
        aes_sbox_cf u_sbox (
            .x  (sub_in[k]),
            .inv(inv_q),
            .y  (sub_out[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            work      <= '0;
            cnt       <= '0;
            inv_q     <= 1'b0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= in_state;
                        inv_q     <= in_inv;
                        cnt       <= '0;
                        fsm_state <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NUM_SBOX; k++) work[base + 4'(k)] <= sub_out[k];
                    if (cnt == LAST_ITER) begin
                        cnt       <= '0;
                        fsm_state <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_state <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Self-checking bench for aes_sub_bytes_iter: FIPS-197 vectors, handshake corner cases and
// randomized blocks checked against a plain GF(2^8) reference S-box.
module tb_aes_sub_bytes_iter;
    import aes_pkg::*;

    localparam int NUM_SBOX = 4;
    localparam int NUM_ITER = 16 / NUM_SBOX;

    logic     clk = 1'b0;
    logic     rst;
    logic     in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    state_t   in_state, out_state;
    sub_fsm_e fsm_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_tab [256];
    logic [7:0] inv_tab  [256];

    typedef struct {
        string        name;
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [8];

    aes_sub_bytes_iter #(.NUM_SBOX(NUM_SBOX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1, inverse by search, FIPS affine bit rule.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] c, v, s, inv_v;
        c = 8'h63;
        for (int n = 0; n < 256; n++) begin
            v = 8'(n);
            inv_v = 8'h00;
            for (int m = 1; m < 256; m++) if (gmul(v, 8'(m)) == 8'h01) inv_v = 8'(m);
            for (int i = 0; i < 8; i++)
                s[i] = inv_v[i] ^ inv_v[(i+4)%8] ^ inv_v[(i+5)%8] ^ inv_v[(i+6)%8] ^ inv_v[(i+7)%8] ^ c[i];
            sbox_tab[n] = s;
            inv_tab[s]  = v;
        end
    endtask

    function automatic logic [127:0] ref_state(input logic [127:0] din, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = din[127-8*i -: 8];
            r[127-8*i -: 8] = inv ? inv_tab[b] : sbox_tab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Accepts one block, scrambles in_* during RUN, measures latency and completes the output handshake.
    task automatic run_block(input string name, input logic [127:0] din, input logic inv,
                             output logic [127:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        in_state = din; in_inv = inv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_state = rand128(); in_inv = 1'($urandom);
        wait_out_valid(lat);
        res = out_state;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_release"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
    endtask

    initial begin
        logic [127:0] res, din, exp;
        int           lat;
        logic         inv;

        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b0;
        build_tables();
        vecs[0] = '{"sb_zero", 128'h0, 1'b0, {16{8'h63}}};
        vecs[1] = '{"sb_01", {8'h01, 120'h0}, 1'b0, {8'h7c, {15{8'h63}}}};
        vecs[2] = '{"sb_53", {8'h53, 120'h0}, 1'b0, {8'hed, {15{8'h63}}}};
        vecs[3] = '{"sb_ff", {8'hff, 120'h0}, 1'b0, {8'h16, {15{8'h63}}}};
        vecs[4] = '{"fips_fwd", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[5] = '{"fips_inv", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[6] = '{"isb_63", {8'h63, 120'h0}, 1'b1, {8'h00, {15{8'h52}}}};
        vecs[7] = '{"isb_zero", 128'h0, 1'b1, {16{8'h52}}};

        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        check("reset_state", out_state, 128'h0);
        check("reset_fsm", 128'(fsm_state), 128'(IDLE));
        rst = 1'b0;

        // Table-driven FIPS vectors, with the model cross-checked against the same constants.
        for (int v = 0; v < 8; v++) begin
            check({vecs[v].name, "_model"}, ref_state(vecs[v].din, vecs[v].inv), vecs[v].exp);
            run_block(vecs[v].name, vecs[v].din, vecs[v].inv, res, lat);
            check(vecs[v].name, res, vecs[v].exp);
            check({vecs[v].name, "_latency"}, 128'(lat), 128'(NUM_ITER));
        end

        // Backpressure: output held 10 cycles while upstream offers junk.
        in_state = vecs[4].din; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid(lat);
        check("bp_latency", 128'(lat), 128'(NUM_ITER));
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_state = rand128(); in_inv = 1'($urandom);
            @(posedge clk); #1;
            check("bp_state", out_state, vecs[4].exp);
            check("bp_flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
        end
        // Release with in_valid still high: no acceptance in DONE, next block taken one cycle later.
        in_state = vecs[5].din; in_inv = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_accept", 128'({in_ready, busy}), 128'(2'b01));
        wait_out_valid(lat);
        check("b2b_latency", 128'(lat), 128'(NUM_ITER));
        check("b2b_state", out_state, vecs[5].exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset two iterations into RUN aborts the block.
        in_state = rand128(); in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        check("midrst_state", out_state, 128'h0);
        check("midrst_fsm", 128'(fsm_state), 128'(IDLE));
        run_block("post_rst", vecs[4].din, 1'b0, res, lat);
        check("post_rst", res, vecs[4].exp);

        // Random blocks against the reference model.
        for (int r = 0; r < 24; r++) begin
            din = rand128(); inv = 1'($urandom_range(0, 1));
            exp = ref_state(din, inv);
            run_block("rand", din, inv, res, lat);
            check("rand", res, exp);
            check("rand_latency", 128'(lat), 128'(NUM_ITER));
        end

        // Every byte value through both directions.
        for (int s = 0; s < 32; s++) begin
            for (int i = 0; i < 16; i++) din[127-8*i -: 8] = 8'(16 * (s % 16) + i);
            inv = (s >= 16);
            exp = ref_state(din, inv);
            run_block("sweep", din, inv, res, lat);
            check(inv ? "sweep_inv" : "sweep_fwd", res, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
